// File: rtl/pci_pkg.sv
// pci_pkg -- shared definitions for the PCI arbiter and the PCI device model.
//   state_t          : arbiter FSM states (IDLE, GRANT, BUSY, TURN)
//   NUM_MASTERS_DEF  : default number of requesting devices
//   GNT_TIMEOUT_DEF  : default grant hold time, in cycles, before revocation
//   idx_w()          : width of an index into n devices
package pci_pkg;

  localparam int NUM_MASTERS_DEF = 3;
  localparam int GNT_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_arbiter_if.sv
// pci_arbiter_if -- request/grant and shared bus-status signals.
//   req_n    : per-device bus request, active-low      (device -> arbiter)
//   frame_n  : shared FRAME#, active-low               (device -> arbiter)
//   irdy_n   : shared IRDY#, active-low                (device -> arbiter)
//   gnt_n    : per-device grant, active-low            (arbiter -> device)
//   owner    : index of the most recently granted device
//   bus_busy : high while a transaction is in progress
// Modport master is the bus-master (device) side, slave is the arbiter side.
interface pci_arbiter_if
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF
) ();

  logic [NUM_MASTERS-1:0]        req_n;
  logic                          frame_n;
  logic                          irdy_n;
  logic [NUM_MASTERS-1:0]        gnt_n;
  logic [idx_w(NUM_MASTERS)-1:0] owner;
  logic                          bus_busy;

  modport master (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, bus_busy
  );

  modport slave (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, bus_busy
  );

endinterface

// File: rtl/pci_rr_pick.sv
// pci_rr_pick -- combinational round-robin picker.
//   req    : active-high request vector
//   last   : index of the previous winner; search starts at last+1
//   winner : first requesting index found, ascending with wrap-around
//   valid  : at least one request present
module pci_rr_pick
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  localparam int OW         = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OW-1:0]          last,
  output logic [OW-1:0]          winner,
  output logic                   valid
);

  logic [OW-1:0] cand;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    // Offset 1..NUM_MASTERS visits last+1 first and last itself at the end,
    // so the previous owner only wins again when nobody else is asking.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = OW'((int'(last) + i) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter -- round-robin PCI bus arbiter with grant timeout.
//   clk   : bus clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : pci_arbiter_if.slave (req_n/frame_n/irdy_n in;
//           gnt_n/owner/bus_busy out, all registered)
// Grants one device per arbitration, revokes an unused grant after
// GNT_TIMEOUT cycles or when the owner withdraws, and always inserts a
// TURN + IDLE gap between the end of one transaction and the next grant.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pci_arbiter_if.slave  bus
);

  localparam int OW = idx_w(NUM_MASTERS);
  localparam int CW = $clog2(GNT_TIMEOUT + 1);
  localparam logic [CW-1:0]          CNT_MAX  = CW'(GNT_TIMEOUT);
  localparam logic [NUM_MASTERS-1:0] ALL_OFF  = '1;
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [OW-1:0]          owner_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic                   busy_q;

  logic [NUM_MASTERS-1:0] req_act;
  logic [OW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [CW-1:0]          cnt_next;
  logic                   timeout;

  assign req_act = ~bus.req_n;

  pci_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req    (req_act),
    .last   (owner_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Saturating grant-age counter; expiry is judged on the value this edge
  // would load, so the grant is low for exactly GNT_TIMEOUT cycles.
  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign timeout  = (cnt_next == CNT_MAX);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_q   <= ALL_OFF;
      owner_q <= OW'(NUM_MASTERS - 1);
      busy_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_q   <= ~(ONE_HOT0 << pick_idx);
            owner_q <= pick_idx;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          cnt <= cnt_next;
          // A FRAME# start beats both withdrawal and timeout.
          if (!bus.frame_n) begin
            gnt_q  <= ALL_OFF;
            busy_q <= 1'b1;
            state  <= BUSY;
          end else if (bus.req_n[owner_q] || timeout) begin
            // owner_q is kept so the next search starts past this device.
            gnt_q <= ALL_OFF;
            state <= TURN;
          end
        end
        BUSY: begin
          if (bus.frame_n && bus.irdy_n) begin
            busy_q <= 1'b0;
            state  <= TURN;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          gnt_q  <= ALL_OFF;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_n    = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = busy_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter -- directed scoreboard bench for pci_arbiter (3 devices,
// timeout 16). Stimulus pushes the expected post-edge outputs tagged with
// the edge number; a negedge monitor pops and compares them.
module tb_pci_arbiter;
  import pci_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic armed = 1'b0;

  typedef struct {
    int         at;
    logic [2:0] gnt;
    logic [1:0] own;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pci_arbiter_if #(.NUM_MASTERS(3)) bus ();

  pci_arbiter #(.NUM_MASTERS(3), .GNT_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: outputs after edge N are compared at the following negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        check({e.name, "_missed"}, 32'(cyc), 32'(e.at));
      end else begin
        check({e.name, "_gnt_n"},    32'(bus.gnt_n),    32'(e.gnt));
        check({e.name, "_owner"},    32'(bus.owner),    32'(e.own));
        check({e.name, "_bus_busy"}, 32'(bus.bus_busy), 32'(e.busy));
      end
    end
    if (armed && $countones(~bus.gnt_n) > 1)
      check("one_grant_max", 32'($countones(~bus.gnt_n)), 32'd1);
  end

  function automatic logic [2:0] gnt_of(input int n);
    logic [2:0] one;
    one = 3'b001;
    return ~(one << n);
  endfunction

  // Drive inputs for the next edge and record the outputs expected after it.
  task automatic step(input logic rst, input logic [2:0] rq, input logic fr,
                      input logic ir, input logic [2:0] eg, input logic [1:0] eo,
                      input logic eb, input string nm);
    exp_t x;
    reset       = rst;
    bus.req_n   = rq;
    bus.frame_n = fr;
    bus.irdy_n  = ir;
    x.at = cyc + 1; x.gnt = eg; x.own = eo; x.busy = eb; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    bus.req_n   = 3'b111;
    bus.frame_n = 1'b1;
    bus.irdy_n  = 1'b1;
    @(posedge clk);
    #1;

    // Reset, first grant, transaction start.
    step(1, 3'b111, 1, 1, 3'b111, 2'd2, 0, "reset");
    armed = 1'b1;
    step(0, 3'b110, 1, 1, 3'b110, 2'd0, 0, "first_grant");
    step(0, 3'b110, 0, 0, 3'b111, 2'd0, 1, "frame_busy");
    step(0, 3'b111, 0, 1, 3'b111, 2'd0, 1, "busy_frame_low");
    step(0, 3'b111, 1, 0, 3'b111, 2'd0, 1, "busy_irdy_low");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "busy_exit_turn");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "turn_to_idle");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "idle_no_req");

    // Reset while BUSY with FRAME# low.
    step(0, 3'b110, 1, 1, 3'b110, 2'd0, 0, "regrant_0");
    step(0, 3'b110, 0, 0, 3'b111, 2'd0, 1, "busy_again");
    step(1, 3'b110, 0, 0, 3'b111, 2'd2, 0, "reset_in_busy");
    step(0, 3'b111, 0, 0, 3'b111, 2'd2, 0, "idle_after_reset");

    // All request: round-robin 0,1,2,0 with a two-cycle gap after BUSY.
    step(1, 3'b111, 1, 1, 3'b111, 2'd2, 0, "reset_rr");
    step(0, 3'b000, 1, 1, 3'b110, 2'd0, 0, "rr_grant");
    for (int k = 0; k < 3; k++) begin
      step(0, 3'b000, 0, 0, 3'b111, 2'(k), 1, "rr_busy");
      step(0, 3'b000, 1, 0, 3'b111, 2'(k), 1, "rr_last_data");
      step(0, 3'b000, 1, 1, 3'b111, 2'(k), 0, "rr_turn");
      step(0, 3'b000, 1, 1, 3'b111, 2'(k), 0, "rr_idle");
      step(0, 3'b000, 1, 1, gnt_of((k + 1) % 3), 2'((k + 1) % 3), 0, "rr_grant");
    end
    step(0, 3'b111, 0, 0, 3'b111, 2'd0, 1, "rr_final_busy");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "rr_final_turn");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "rr_final_idle");

    // Timeout: device 1 never starts, grant held exactly 16 cycles.
    step(1, 3'b111, 1, 1, 3'b111, 2'd2, 0, "reset_to");
    step(0, 3'b001, 1, 1, 3'b101, 2'd1, 0, "to_grant");
    for (int i = 1; i <= 15; i++)
      step(0, 3'b001, 1, 1, 3'b101, 2'd1, 0, "to_hold");
    step(0, 3'b001, 1, 1, 3'b111, 2'd1, 0, "to_revoke");
    step(0, 3'b001, 1, 1, 3'b111, 2'd1, 0, "to_idle");
    step(0, 3'b001, 1, 1, 3'b011, 2'd2, 0, "to_next_dev2");

    // Device 2 withdraws before FRAME#.
    step(0, 3'b111, 1, 1, 3'b111, 2'd2, 0, "withdraw_turn");
    step(0, 3'b111, 1, 1, 3'b111, 2'd2, 0, "withdraw_idle");
    step(0, 3'b111, 1, 1, 3'b111, 2'd2, 0, "withdraw_stay_idle");

    // FRAME# low in the very cycle the timeout expires: BUSY wins.
    step(1, 3'b111, 1, 1, 3'b111, 2'd2, 0, "reset_race");
    step(0, 3'b110, 1, 1, 3'b110, 2'd0, 0, "race_grant");
    for (int i = 1; i <= 15; i++)
      step(0, 3'b110, 1, 1, 3'b110, 2'd0, 0, "race_hold");
    step(0, 3'b110, 0, 0, 3'b111, 2'd0, 1, "race_busy");
    step(0, 3'b111, 0, 0, 3'b111, 2'd0, 1, "race_busy_hold");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "race_turn");
    step(0, 3'b111, 1, 1, 3'b111, 2'd0, 0, "race_idle");

    // Bounded drain of the scoreboard.
    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3: number of requesting devices (legal 2..8).
REQ-002 Parameter GNT_TIMEOUT, default 16: cycles a grant is held without frame_n assertion before revocation.
REQ-003 clk  input  1  bus clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_n  input  NUM_MASTERS  per-device bus request, active-low.
REQ-006 frame_n  input  1  shared FRAME#, active-low.
REQ-007 irdy_n  input  1  shared IRDY#, active-low.
REQ-008 gnt_n  output  NUM_MASTERS  per-device grant, active-low, registered.
REQ-009 owner  output  $clog2(NUM_MASTERS)  index of most recently granted device, registered.
REQ-010 bus_busy  output  1  high while FSM in BUSY, registered.

Function
REQ-011 FSM states IDLE, GRANT, BUSY, TURN; all outputs driven from registers.
REQ-012 IDLE, any req_n bit low at edge k: winner's gnt_n bit low, owner loaded, state GRANT, all after edge k (one-cycle request-to-grant); no request: gnt_n all ones, stay IDLE.
REQ-013 Round-robin: search starts at owner+1, ascending, wrapping modulo NUM_MASTERS; exactly one winner.
REQ-014 GRANT, frame_n sampled low: gnt_n all ones, state BUSY, bus_busy 1.
REQ-015 GRANT, owner's req_n sampled high with frame_n high: grant revoked, state TURN.
REQ-016 GRANT timeout: counter cleared on entry, increments each GRANT cycle; count reaching GNT_TIMEOUT with frame_n high revokes grant, state TURN; owner retained so next search skips it.
REQ-017 Simultaneous frame_n low with timeout expiry or request withdrawal: BUSY wins, no revocation.
REQ-018 BUSY: stay while frame_n low or irdy_n low; both high sampled -> TURN, bus_busy 0.
REQ-019 TURN: exactly one cycle, gnt_n all ones, then IDLE.
REQ-020 Minimum two edges from bus-idle detection to next gnt_n assertion (TURN, IDLE).
REQ-021 At most one gnt_n bit low at any time; gnt_n all ones in BUSY and TURN.
REQ-022 Counter width $clog2(GNT_TIMEOUT+1); saturates, never wraps.

Reset
REQ-023 reset high at edge: state IDLE, gnt_n all ones, owner NUM_MASTERS-1 (device 0 wins first), bus_busy 0, counter 0.
REQ-024 reset overrides every state including BUSY; grant removal not conditioned on frame_n/irdy_n.

Structure
REQ-025 Package pci_pkg: state enum (IDLE, GRANT, BUSY, TURN) and NUM_MASTERS/GNT_TIMEOUT defaults, shared with the PCI device model.
REQ-026 One sub-module pci_rr_pick: combinational round-robin picker (req vector, last owner -> winner index, valid).

Verification
REQ-027 Reset, req_n=3'b110 -> next cycle gnt_n=3'b110, owner=0; frame_n low -> gnt_n=3'b111, bus_busy=1.
REQ-028 req_n=3'b000 held, each master runs 2-cycle transaction -> grant order 0,1,2,0, two idle cycles between BUSY exit and next grant.
REQ-029 req_n=3'b001, master 1 never drives frame_n -> gnt_n[1] low exactly 16 cycles, TURN, then gnt_n=3'b011 (device 2).
REQ-030 Device 2 granted, req_n[2] released before frame_n -> gnt_n=3'b111 next cycle, TURN, IDLE.
REQ-031 frame_n low in the cycle counter reaches 16 -> BUSY, gnt_n bit never re-asserted, bus_busy=1.
REQ-032 reset during BUSY (frame_n low) -> gnt_n=3'b111, owner=2, bus_busy=0, IDLE after that edge.
